// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- RV64I instruction-decode pipeline stage (IF -> ID -> EX).
//
// Accepts {pc, inst} from IF over a valid/ready handshake and holds it in a
// stage register. The head entry is decoded combinationally into register
// indices, a sign-extended immediate, a format code and an illegal flag.
// The outputs obey EX's valid/ready backpressure.
//
// Optional feature macro: ID_SKID_EN
//   defined   : two-entry stage (main + skid); ID_ready_o = !skid_valid
//               comes straight from a register, so there is no
//               combinational path from EX_ready_i to ID_ready_o.
//   undefined : single entry; ID_ready_o = !main_valid || EX_ready_i.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   IF_pc_i       pc of the offered instruction (XLEN)
//   IF_inst_i     offered instruction word (32)
//   IF_valid_i    IF offers an instruction
//   ID_ready_o    ID accepts this cycle
//   EX_ready_i    EX accepts this cycle
//   ID_valid_o    head entry is valid
//   ID_flush_i    discard all held and offered instructions
//   ID_pc_o       head pc
//   ID_inst_o     head raw instruction
//   ID_rd_o/ID_rs1_o/ID_rs2_o  register indices
//   ID_imm_o      sign-extended immediate (0 for R-type and illegal)
//   ID_fmt_o      0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//   ID_illegal_o  unsupported opcode
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IF_pc_i,
  input  logic [31:0]     IF_inst_i,
  input  logic            IF_valid_i,
  output logic            ID_ready_o,
  input  logic            EX_ready_i,
  output logic            ID_valid_o,
  input  logic            ID_flush_i,
  output logic [XLEN-1:0] ID_pc_o,
  output logic [31:0]     ID_inst_o,
  output logic [4:0]      ID_rd_o,
  output logic [4:0]      ID_rs1_o,
  output logic [4:0]      ID_rs2_o,
  output logic [XLEN-1:0] ID_imm_o,
  output logic [2:0]      ID_fmt_o,
  output logic            ID_illegal_o
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [6:0] {
    OP_OP     = 7'b0110011,
    OP_OP32   = 7'b0111011,
    OP_IMM    = 7'b0010011,
    OP_IMM32  = 7'b0011011,
    OP_LOAD   = 7'b0000011,
    OP_JALR   = 7'b1100111,
    OP_SYSTEM = 7'b1110011,
    OP_FENCE  = 7'b0001111,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // Main (head) entry
  logic            r_main_valid;
  logic [XLEN-1:0] r_main_pc;
  logic [31:0]     r_main_inst;

  logic w_in_fire;
  logic w_main_free;

  assign w_in_fire   = IF_valid_i && ID_ready_o;
  // Main can take a new value when empty or when EX consumes it this edge.
  assign w_main_free = !r_main_valid || EX_ready_i;

`ifdef ID_SKID_EN
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_skid_inst;

  assign ID_ready_o = !r_skid_valid;

  // Ready is !skid_valid, so an accepted input always finds skid empty;
  // when skid is occupied no input can be accepted on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_inst  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_inst  <= '0;
    end else if (ID_flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_pc    <= r_skid_pc;
        r_main_inst  <= r_skid_inst;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_in_fire;
        if (w_in_fire) begin
          r_main_pc   <= IF_pc_i;
          r_main_inst <= IF_inst_i;
        end
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_pc    <= IF_pc_i;
      r_skid_inst  <= IF_inst_i;
    end
  end
`else
  assign ID_ready_o = w_main_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_valid <= 1'b0;
      r_main_pc    <= '0;
      r_main_inst  <= '0;
    end else if (ID_flush_i) begin
      r_main_valid <= 1'b0;
    end else if (w_main_free) begin
      r_main_valid <= w_in_fire;
      if (w_in_fire) begin
        r_main_pc   <= IF_pc_i;
        r_main_inst <= IF_inst_i;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Combinational decode of the head instruction
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] w_imm;
  fmt_e            w_fmt;
  logic [31:0]     w_i;

  assign w_i = r_main_inst;

  // Opcodes with inst[1:0] != 2'b11 fall into default and decode illegal.
  always_comb begin
    w_imm = '0;
    w_fmt = FMT_ILL;
    case (w_i[6:0])
      OP_OP, OP_OP32: begin
        w_fmt = FMT_R;
      end
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        w_fmt = FMT_I;
        w_imm = {{(XLEN-12){w_i[31]}}, w_i[31:20]};
      end
      OP_STORE: begin
        w_fmt = FMT_S;
        w_imm = {{(XLEN-12){w_i[31]}}, w_i[31:25], w_i[11:7]};
      end
      OP_BRANCH: begin
        w_fmt = FMT_B;
        w_imm = {{(XLEN-13){w_i[31]}}, w_i[31], w_i[7], w_i[30:25],
                 w_i[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt = FMT_U;
        w_imm = {{(XLEN-32){w_i[31]}}, w_i[31:12], 12'b0};
      end
      OP_JAL: begin
        w_fmt = FMT_J;
        w_imm = {{(XLEN-21){w_i[31]}}, w_i[31], w_i[19:12], w_i[20],
                 w_i[30:21], 1'b0};
      end
      default: begin
        w_fmt = FMT_ILL;
        w_imm = '0;
      end
    endcase
  end

  assign ID_valid_o   = r_main_valid;
  assign ID_pc_o      = r_main_pc;
  assign ID_inst_o    = r_main_inst;
  assign ID_rd_o      = w_i[11:7];
  assign ID_rs1_o     = w_i[19:15];
  assign ID_rs2_o     = w_i[24:20];
  assign ID_imm_o     = w_imm;
  assign ID_fmt_o     = w_fmt;
  assign ID_illegal_o = (w_fmt == FMT_ILL);

endmodule
